iob_ctrl: RTL and testbench
===========================

IOB_CTRL -- requirements
Module: iob_ctrl

Interface
REQ-001 The block SHALL have parameter NSLV, default 4, giving the number of peripheral slots (power of two, 2..8).
REQ-002 The block SHALL have parameter TMO, default 16, giving the number of wait cycles before an access times out (2..255).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 hs_ls4iob_val  input  1  LSU request valid.
REQ-006 i_adr  input  32  request address.
REQ-007 i_wdat  input  32  write data.
REQ-008 i_wen  input  4  byte write enables; 0 means read.
REQ-009 hs_iob4ls_rdy  output  1  one-cycle response strobe to the LSU.
REQ-010 o_rdat  output  32  read data, valid while hs_iob4ls_rdy=1.
REQ-011 o_err  output  1  response error flag, valid while hs_iob4ls_rdy=1.
REQ-012 o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 o_pv  output  NSLV  one-hot peripheral select/valid.
REQ-014 o_padr  output  12  peripheral offset, i_adr[11:0] as latched.
REQ-015 o_pwdat  output  32  latched write data.
REQ-016 o_pwen  output  4  latched byte enables.
REQ-017 i_prdy  input  NSLV  per-slot ready.
REQ-018 i_prdat  input  NSLV*32  per-slot read data; slot k occupies bits [32k+31:32k].

Function
REQ-019 Decode: slot = i_adr[11+log2(NSLV):12]; the request is a decode error if i_adr[15:12+log2(NSLV)] is nonzero.
REQ-020 The FSM SHALL have the states IDLE, ACC and RESP.
REQ-021 In IDLE with hs_ls4iob_val=1, the block SHALL latch adr, wdat, wen and slot, and go to ACC; on a decode error it SHALL go directly to RESP with err=1.
REQ-022 Requests SHALL be sampled only in IDLE; val in ACC or RESP SHALL be ignored and not queued.
REQ-023 In ACC, o_pv SHALL equal one-hot(slot), and o_padr, o_pwdat and o_pwen SHALL hold the latched values, stable for the whole of ACC.
REQ-024 In ACC, if i_prdy[slot]=1, the block SHALL capture the slot's i_prdat (or 0 for writes) into the response register with err=0, and go to RESP; i_prdy of non-selected slots SHALL be ignored.
REQ-025 In ACC, an 8-bit wait counter SHALL be cleared on ACC entry and increment each ACC cycle without ready.
REQ-026 When the counter equals TMO-1 and ready is low, the access SHALL time out: go to RESP with err=1.
REQ-027 If ready and the timeout occur in the same cycle, ready SHALL win (err=0).
REQ-028 In RESP, hs_iob4ls_rdy SHALL be 1 for exactly one cycle, and the FSM SHALL go to IDLE.
REQ-029 Outside RESP, hs_iob4ls_rdy SHALL be 0.
REQ-030 On error (decode or timeout), o_rdat SHALL be 32'hDEAD_BEEF.
REQ-031 Outside RESP, o_rdat SHALL hold its last value and o_err SHALL be 0.
REQ-032 Latency: a request sampled at edge t with ready already high SHALL produce ACC in cycle t+1 and rdy in cycle t+2. A decode error SHALL produce rdy in cycle t+1.
REQ-033 Outside ACC, o_pv SHALL be all zeros.
REQ-034 o_busy SHALL be 1 in ACC and RESP.

Reset
REQ-035 While rst=1, the FSM SHALL be IDLE and the counter 0.
REQ-036 While rst=1, hs_iob4ls_rdy, o_err, o_busy and o_pv SHALL be 0, and o_rdat, o_padr, o_pwdat and o_pwen SHALL be 0.
REQ-037 Reset asserted mid-ACC SHALL drop o_pv immediately (asynchronously), with no response issued.
REQ-038 After deassertion, the first request SHALL be accepted on the next edge.

Verification
REQ-039 Read, slot 2 ready immediately: adr 0x2010, wen 0, prdat[2]=0x1234_5678 -> o_pv=4'b0100 for 1 cycle; rdy at t+2 with o_rdat=0x1234_5678 and o_err=0.
REQ-040 Write, slot 1 ready after 3 cycles: adr 0x1004, wen 4'hF, wdat 0xA5A5_0001 -> o_pwen=F and o_pwdat stable for 4 ACC cycles; one rdy pulse with err=0.
REQ-041 Timeout, TMO=16, slot 3 never ready -> o_pv high for 16 cycles; rdy with o_rdat=0xDEAD_BEEF and err=1.
REQ-042 Decode error: adr 0x4000 with NSLV=4 -> no o_pv; rdy at t+1 with err=1 and rdat=0xDEAD_BEEF.
REQ-043 Ready coincident with the timeout cycle, and a second val held during ACC -> err=0 and real data returned; exactly one rdy, and the held val is accepted only after returning to IDLE.
REQ-044 rst pulsed during ACC -> o_pv=0 and busy=0 at once; no rdy; the next request completes normally.

Source files
------------

// File: rtl/iob_ctrl.sv
// IO bus controller: routes one LSU access at a time to a peripheral slot, waits for its ready or a timeout.
// Response strobe two cycles after acceptance with ready high (one for decode errors); new requests only taken in IDLE.
module iob_ctrl #(
  parameter int NSLV = 4,
  parameter int TMO  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hs_ls4iob_val,
  input  logic [31:0]        i_adr,
  input  logic [31:0]        i_wdat,
  input  logic [3:0]         i_wen,
  output logic               hs_iob4ls_rdy,
  output logic [31:0]        o_rdat,
  output logic               o_err,
  output logic               o_busy,
  output logic [NSLV-1:0]    o_pv,
  output logic [11:0]        o_padr,
  output logic [31:0]        o_pwdat,
  output logic [3:0]         o_pwen,
  input  logic [NSLV-1:0]    i_prdy,
  input  logic [NSLV*32-1:0] i_prdat
);
  localparam int SW = $clog2(NSLV);
  localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t          state_q;
  logic [SW-1:0]   slot_q;
  logic [7:0]      cnt_q;
  logic            rdy_q;
  logic            err_q;
  logic            busy_q;
  logic [31:0]     rdat_q;
  logic [NSLV-1:0] pv_q;
  logic [11:0]     padr_q;
  logic [31:0]     pwdat_q;
  logic [3:0]      pwen_q;

  logic [SW-1:0]   req_slot;
  logic            req_dec_err;
  logic            sel_rdy;
  logic [31:0]     sel_dat;
  logic            unused_adr;

  assign req_slot    = i_adr[12 +: SW];
  assign req_dec_err = (i_adr[15:12] >> SW) != 4'd0;
  assign unused_adr  = ^i_adr[31:16];

  always_comb begin
    sel_rdy = 1'b0;
    sel_dat = 32'd0;
    for (int k = 0; k < NSLV; k++) begin
      if (slot_q == SW'(k)) begin
        sel_rdy = i_prdy[k];
        sel_dat = i_prdat[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= 8'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdat_q  <= 32'd0;
      pv_q    <= '0;
      padr_q  <= 12'd0;
      pwdat_q <= 32'd0;
      pwen_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_ls4iob_val) begin
            padr_q  <= i_adr[11:0];
            pwdat_q <= i_wdat;
            pwen_q  <= i_wen;
            slot_q  <= req_slot;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
            if (req_dec_err) begin
              state_q <= RESP;
              rdy_q   <= 1'b1;
              err_q   <= 1'b1;
              rdat_q  <= ERR_DAT;
            end else begin
              state_q <= ACC;
              pv_q    <= NSLV'(1) << req_slot;
            end
          end
        end
        ACC: begin
          // Ready is checked before the timeout so a late ready still returns data.
          if (sel_rdy) begin
            state_q <= RESP;
            pv_q    <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            rdat_q  <= (pwen_q == 4'd0) ? sel_dat : 32'd0;
          end else if (cnt_q == 8'(TMO - 1)) begin
            state_q <= RESP;
            pv_q    <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            rdat_q  <= ERR_DAT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hs_iob4ls_rdy = rdy_q;
  assign o_rdat        = rdat_q;
  assign o_err         = err_q;
  assign o_busy        = busy_q;
  assign o_pv          = pv_q;
  assign o_padr        = padr_q;
  assign o_pwdat       = pwdat_q;
  assign o_pwen        = pwen_q;

endmodule

// File: tb/tb_iob_ctrl.sv
// Bench for iob_ctrl: fixed vectors, random accesses against an outcome model, and reset corner cases.
module tb_iob_ctrl;
  localparam int NSLV = 4;
  localparam int TMO  = 16;
  localparam int SW   = $clog2(NSLV);
  localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

  logic               clk = 1'b0;
  logic               rst;
  logic               hs_ls4iob_val;
  logic [31:0]        i_adr;
  logic [31:0]        i_wdat;
  logic [3:0]         i_wen;
  logic               hs_iob4ls_rdy;
  logic [31:0]        o_rdat;
  logic               o_err;
  logic               o_busy;
  logic [NSLV-1:0]    o_pv;
  logic [11:0]        o_padr;
  logic [31:0]        o_pwdat;
  logic [3:0]         o_pwen;
  logic [NSLV-1:0]    i_prdy;
  logic [NSLV*32-1:0] i_prdat;

  iob_ctrl #(.NSLV(NSLV), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .hs_ls4iob_val(hs_ls4iob_val), .i_adr(i_adr), .i_wdat(i_wdat), .i_wen(i_wen),
    .hs_iob4ls_rdy(hs_iob4ls_rdy), .o_rdat(o_rdat), .o_err(o_err), .o_busy(o_busy),
    .o_pv(o_pv), .o_padr(o_padr), .o_pwdat(o_pwdat), .o_pwen(o_pwen),
    .i_prdy(i_prdy), .i_prdat(i_prdat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    int          dly;    // ACC cycles the target slot keeps ready low
    logic [31:0] pdat;
    bit          hold;   // keep val high through the access and one idle cycle
    int          e_pv;   // expected number of cycles with o_pv active
    int          e_lat;  // expected cycles from sampling edge to rdy cycle
    logic [31:0] e_rdat;
    logic        e_err;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Outcome of one access derived from the decode/ready/timeout rules.
  function automatic vec_t model(input logic [31:0] adr, input logic [31:0] wdat,
                                 input logic [3:0] wen, input int dly, input logic [31:0] pdat);
    vec_t v;
    v.adr = adr; v.wdat = wdat; v.wen = wen; v.dly = dly; v.pdat = pdat; v.hold = 1'b0;
    if (int'(adr[15:12]) >= NSLV) begin
      v.e_pv = 0; v.e_lat = 1; v.e_rdat = ERR_DAT; v.e_err = 1'b1;
    end else if (dly < TMO) begin
      v.e_pv = dly + 1; v.e_lat = dly + 2; v.e_err = 1'b0;
      v.e_rdat = (wen == 4'd0) ? pdat : 32'd0;
    end else begin
      v.e_pv = TMO; v.e_lat = TMO + 1; v.e_rdat = ERR_DAT; v.e_err = 1'b1;
    end
    return v;
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    logic [NSLV-1:0] exp_oh, pv_seen;
    logic [31:0] rdat;
    logic err;
    int pv_cyc, lat, nrdy, c, slot;
    bit dec, stab_ok, pv_ok, quiet_ok, hold_idle_ok, hold_acc_ok;
    dec  = int'(v.adr[15:12]) >= NSLV;
    slot = int'(v.adr[12 +: SW]);
    exp_oh = dec ? '0 : (NSLV'(1) << slot);
    for (int k = 0; k < NSLV; k++) i_prdat[32*k +: 32] = 32'hBAD0_0000 + 32'(k);
    if (!dec) i_prdat[32*slot +: 32] = v.pdat;
    i_prdy = ~exp_oh;  // other slots ready: must be ignored
    hs_ls4iob_val = 1'b1; i_adr = v.adr; i_wdat = v.wdat; i_wen = v.wen;
    pv_cyc = 0; lat = 0; nrdy = 0; pv_seen = '0; rdat = '0; err = 1'b0;
    stab_ok = 1; pv_ok = 1; quiet_ok = 1; hold_idle_ok = 1; hold_acc_ok = 1;
    c = 0;
    while (c < 300 && (lat == 0 || c < lat + 2)) begin
      @(negedge clk);
      c++;
      if (!v.hold) hs_ls4iob_val = 1'b0;
      if (nrdy == 0 && o_pv != '0) begin
        pv_cyc++;
        pv_seen |= o_pv;
        if (o_pv != exp_oh) pv_ok = 0;
        if (o_padr != v.adr[11:0] || o_pwdat != v.wdat || o_pwen != v.wen || !o_busy) stab_ok = 0;
      end
      if (hs_iob4ls_rdy) begin
        nrdy++;
        if (lat == 0) begin lat = c; rdat = o_rdat; err = o_err; end
      end else if (o_err) quiet_ok = 0;
      if (v.hold && lat != 0 && c == lat + 1 && (o_busy || o_pv != '0)) hold_idle_ok = 0;
      if (v.hold && lat != 0 && c == lat + 2) begin
        if (o_pv != exp_oh) hold_acc_ok = 0;
        hs_ls4iob_val = 1'b0;
      end
      i_prdy = (pv_cyc > v.dly) ? '1 : ~exp_oh;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(v.e_lat));
    chk({tag, ".pv_cycles"}, 64'(pv_cyc), 64'(v.e_pv));
    chk({tag, ".rdat"}, 64'(rdat), 64'(v.e_rdat));
    chk({tag, ".err"}, 64'(err), 64'(v.e_err));
    chk({tag, ".rdy_pulses"}, 64'(nrdy), 64'd1);
    chk({tag, ".pv_onehot"}, 64'(pv_seen), 64'(exp_oh));
    chk({tag, ".pv_only_slot"}, 64'(pv_ok), 64'd1);
    chk({tag, ".latched_stable"}, 64'(stab_ok), 64'd1);
    chk({tag, ".err_outside_resp"}, 64'(quiet_ok), 64'd1);
    if (v.hold) begin
      chk({tag, ".held_val_idle"}, 64'(hold_idle_ok), 64'd1);
      chk({tag, ".held_val_accepted"}, 64'(hold_acc_ok), 64'd1);
    end
    hs_ls4iob_val = 1'b0;
    i_prdy = '1;
    repeat (4) @(negedge clk);
    chk({tag, ".idle_after"}, 64'(o_busy), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_2010, 32'h0,         4'h0, 0,    32'h1234_5678, 1'b0, 1,  2,  32'h1234_5678, 1'b0};
    vecs[1] = '{32'h0000_1004, 32'hA5A5_0001, 4'hF, 3,    32'h5555_AAAA, 1'b0, 4,  5,  32'h0,         1'b0};
    vecs[2] = '{32'h0000_3000, 32'h0,         4'h0, 1000, 32'h7777_7777, 1'b0, 16, 17, ERR_DAT,       1'b1};
    vecs[3] = '{32'h0000_4000, 32'h0,         4'h0, 0,    32'h1111_1111, 1'b0, 0,  1,  ERR_DAT,       1'b1};
    vecs[4] = '{32'h0000_3ABC, 32'h0,         4'h0, 15,   32'hC0FF_EE00, 1'b1, 16, 17, 32'hC0FF_EE00, 1'b0};
    vecs[5] = '{32'hFFFF_0FFC, 32'h0BAD_CAFE, 4'h3, 14,   32'h9999_0000, 1'b0, 15, 16, 32'h0,         1'b0};
    vecs[6] = '{32'h0000_F123, 32'h0,         4'h0, 0,    32'h0,         1'b0, 0,  1,  ERR_DAT,       1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0,         4'h0, 16,   32'h2222_2222, 1'b0, 16, 17, ERR_DAT,       1'b1};

    // Reset with busy-looking inputs: everything must read zero.
    rst = 1'b1; hs_ls4iob_val = 1'b1; i_adr = 32'h0000_2010; i_wdat = 32'hFFFF_FFFF;
    i_wen = 4'hF; i_prdy = '1; i_prdat = '1;
    repeat (3) @(negedge clk);
    chk("reset.rdy", 64'(hs_iob4ls_rdy), 64'd0);
    chk("reset.err", 64'(o_err), 64'd0);
    chk("reset.busy", 64'(o_busy), 64'd0);
    chk("reset.pv", 64'(o_pv), 64'd0);
    chk("reset.rdat", 64'(o_rdat), 64'd0);
    chk("reset.padr_pwdat_pwen", {16'd0, o_padr, o_pwdat, o_pwen}, 64'd0);
    hs_ls4iob_val = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-access: select drops asynchronously and no response follows.
    i_prdy = '0; hs_ls4iob_val = 1'b1; i_adr = 32'h0000_2000; i_wen = 4'h0;
    @(negedge clk);
    hs_ls4iob_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.pv_before", 64'(o_pv), 64'(4'b0100));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.pv_async", 64'(o_pv), 64'd0);
    chk("rst_mid.busy_async", 64'(o_busy), 64'd0);
    chk("rst_mid.rdy", 64'(hs_iob4ls_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_txn("post_rst", vecs[0]);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] adr;
      logic [3:0]  wen;
      adr = $urandom;
      if ($urandom_range(0, 3) != 0) adr[15:12] = 4'($urandom_range(0, NSLV - 1));
      wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      run_txn($sformatf("rnd%0d", n),
              model(adr, $urandom, wen, int'($urandom_range(0, TMO + 4)), $urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
